// File: rtl/uart_pkg.sv
// Encodings shared by the UART TX and RX halves: FSM state codes and parity type.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Words narrower than 9 bits are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic parTyp);
    return (^data) ^ (parTyp == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Write-side valid/ready handshake into the buffered UART transmitter.
interface uart_tx_buffered_if #(parameter int DATA_WIDTH = 8);

  logic [DATA_WIDTH-1:0] TX_IN_P;
  logic                  TX_IN_V;
  logic                  TX_IN_RDY;

  modport master (output TX_IN_P, output TX_IN_V, input TX_IN_RDY);
  modport slave  (input TX_IN_P, input TX_IN_V, output TX_IN_RDY);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; full and empty come from the occupancy count, so pointers may wrap freely.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pushOk;
  logic                  popOk;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A push is judged against the pre-edge fullness, even when a pop frees a slot on the same edge.
  assign pushOk = push_i && !full_o;
  assign popOk  = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = pushOk ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d = popOk ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d = count_q + CNT_W'(pushOk) - CNT_W'(popOk);
  end

  always_ff @(posedge CLK) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with an input FIFO and built-in baud divider; frame settings are
// captured when each word leaves the FIFO so mid-frame config changes cannot corrupt it.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  uart_tx_buffered_if.slave          txIf,
  input  logic [PRESCALE_WIDTH-1:0]  PRESCALE,
  input  logic                       PAR_EN,
  input  logic                       PAR_TYP,
  input  logic                       STOP2,
  output logic                       TX_OUT_S,
  output logic                       BUSY,
  output logic [$clog2(DEPTH):0]     FIFO_CNT
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0]     fifoData;
  logic                      fifoFull, fifoEmpty, pop;

  uart_state_t               state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] baudCnt_q, baudCnt_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [BIT_W-1:0]          bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      parBit_q, parBit_d;
  logic                      parEn_q, parEn_d;
  logic                      stop2_q, stop2_d;
  logic                      txOut_q, txOut_d;
  logic                      busy_q, busy_d;
  logic                      bitEnd;

  uart_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (txIf.TX_IN_V),
    .data_i  (txIf.TX_IN_P),
    .pop_i   (pop),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (FIFO_CNT)
  );

  assign txIf.TX_IN_RDY = !fifoFull;
  assign TX_OUT_S       = txOut_q;
  assign BUSY           = busy_q;
  assign bitEnd         = (baudCnt_q == presc_q - PRESCALE_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    presc_d   = presc_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parBit_d  = parBit_q;
    parEn_d   = parEn_q;
    stop2_d   = stop2_q;
    txOut_d   = txOut_q;
    busy_d    = busy_q;
    pop       = 1'b0;

    if (state_q != ST_IDLE) baudCnt_d = bitEnd ? '0 : baudCnt_q + PRESCALE_WIDTH'(1);

    case (state_q)
      ST_IDLE:  pop = !fifoEmpty;
      ST_START: if (bitEnd) begin
        state_d  = ST_DATA;
        bitCnt_d = '0;
        txOut_d  = shift_q[0];
      end
      ST_DATA: if (bitEnd) begin
        if (bitCnt_q == LAST_BIT) begin
          bitCnt_d = '0;
          state_d  = parEn_q ? ST_PARITY : ST_STOP;
          txOut_d  = parEn_q ? parBit_q : 1'b1;
        end else begin
          bitCnt_d = bitCnt_q + BIT_W'(1);
          shift_d  = shift_q >> 1;
          txOut_d  = shift_q[1];
        end
      end
      ST_PARITY: if (bitEnd) begin
        state_d  = ST_STOP;
        bitCnt_d = '0;
        txOut_d  = 1'b1;
      end
      ST_STOP: if (bitEnd) begin
        if (stop2_q && bitCnt_q == '0) begin
          bitCnt_d = BIT_W'(1);
        end else if (!fifoEmpty) begin
          pop = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          txOut_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        txOut_d = 1'b1;
      end
    endcase

    // Starting a frame overrides whatever the state branch chose.
    if (pop) begin
      state_d   = ST_START;
      baudCnt_d = '0;
      bitCnt_d  = '0;
      shift_d   = fifoData;
      parBit_d  = parity_bit(9'(fifoData), PAR_TYP);
      parEn_d   = PAR_EN;
      stop2_d   = STOP2;
      presc_d   = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
      txOut_d   = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      baudCnt_q <= '0;
      presc_q   <= PRESCALE_WIDTH'(1);
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parBit_q  <= 1'b0;
      parEn_q   <= 1'b0;
      stop2_q   <= 1'b0;
      txOut_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      presc_q   <= presc_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parBit_q  <= parBit_d;
      parEn_q   <= parEn_d;
      stop2_q   <= stop2_d;
      txOut_q   <= txOut_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: the line and BUSY are logged every cycle and compared
// against waveforms built from frame rules (start, data LSB first, parity, stop bits).
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] w;
    int            presc;
    bit            parEn;
    bit            parTyp;
    bit            stop2;
  } frame_cfg_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [PW-1:0] PRESCALE;
  logic          PAR_EN, PAR_TYP, STOP2;
  logic          TX_OUT_S, BUSY;
  logic [CW-1:0] FIFO_CNT;

  int vectors     = 0;
  int miscompares = 0;

  logic lineLog[$];
  logic busyLog[$];
  logic expLine[$];
  logic expBusy[$];

  uart_tx_buffered_if #(.DATA_WIDTH(DW)) inIf ();

  uart_tx_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PRESCALE_WIDTH(PW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .txIf     (inIf),
    .PRESCALE (PRESCALE),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .STOP2    (STOP2),
    .TX_OUT_S (TX_OUT_S),
    .BUSY     (BUSY),
    .FIFO_CNT (FIFO_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    lineLog.push_back(TX_OUT_S);
    busyLog.push_back(BUSY);
  end

  function automatic int frame_len(input int presc, input bit parEn, input bit stop2);
    int p;
    p = (presc < 1) ? 1 : presc;
    return (2 + DW + int'(parEn) + int'(stop2)) * p;
  endfunction

  // Expected waveform of one frame, appended to the expected queues.
  function automatic void add_frame(input frame_cfg_t c);
    int p;
    bit bits[$];
    p = (c.presc < 1) ? 1 : c.presc;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(c.w[i]);
    if (c.parEn) bits.push_back((($countones(c.w) % 2) == 1) ^ c.parTyp);
    bits.push_back(1'b1);
    if (c.stop2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < p; k++) begin
        expLine.push_back(bits[i]);
        expBusy.push_back(1'b1);
      end
    end
  endfunction

  function automatic void start_capture();
    lineLog.delete();
    busyLog.delete();
    expLine.delete();
    expBusy.delete();
    expLine.push_back(1'b1);
    expBusy.push_back(1'b0);
  endfunction

  function automatic void add_idle_tail(input int n);
    for (int i = 0; i < n; i++) begin
      expLine.push_back(1'b1);
      expBusy.push_back(1'b0);
    end
  endfunction

  task automatic test_reset;
    RST = 1'b0;
    #12;
    vectors += 4;
    if (TX_OUT_S !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx: got %b expected 1", TX_OUT_S); end
    if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    if (inIf.TX_IN_RDY !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rdy: got %b expected 1", inIf.TX_IN_RDY); end
    if (FIFO_CNT !== CW'(0)) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d expected 0", FIFO_CNT); end
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    vectors += 2;
    if (TX_OUT_S !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++; $display("[TB] FAIL post_reset_idle: tx/busy got %b/%b expected 1/0", TX_OUT_S, BUSY);
    end
    if (FIFO_CNT !== CW'(0) || inIf.TX_IN_RDY !== 1'b1) begin
      miscompares++; $display("[TB] FAIL post_reset_fifo: cnt/rdy got %0d/%b expected 0/1", FIFO_CNT, inIf.TX_IN_RDY);
    end
  endtask

  task automatic test_parity;
    frame_cfg_t tbl[5];
    int busyCycles;
    tbl[0] = '{w: 8'hA5, presc: 4, parEn: 1'b1, parTyp: PAR_EVEN, stop2: 1'b0};
    tbl[1] = '{w: 8'hA5, presc: 4, parEn: 1'b1, parTyp: PAR_ODD,  stop2: 1'b0};
    tbl[2] = '{w: 8'hA5, presc: 4, parEn: 1'b0, parTyp: PAR_EVEN, stop2: 1'b1};
    tbl[3] = '{w: 8'h3C, presc: 0, parEn: 1'b1, parTyp: PAR_ODD,  stop2: 1'b1};
    tbl[4] = '{w: 8'h81, presc: 1, parEn: 1'b0, parTyp: PAR_EVEN, stop2: 1'b0};
    foreach (tbl[t]) begin
      PRESCALE = PW'(tbl[t].presc);
      PAR_EN   = tbl[t].parEn;
      PAR_TYP  = tbl[t].parTyp;
      STOP2    = tbl[t].stop2;
      start_capture();
      add_frame(tbl[t]);
      add_idle_tail(3);
      inIf.TX_IN_V = 1'b1;
      inIf.TX_IN_P = tbl[t].w;
      @(negedge CLK);
      inIf.TX_IN_V = 1'b0;
      repeat (expLine.size() - 1) @(negedge CLK);
      vectors++;
      if (lineLog.size() < expLine.size()) begin
        miscompares++; $display("[TB] FAIL parity_len[%0d]: got %0d samples expected %0d", t, lineLog.size(), expLine.size());
      end else begin
        busyCycles = 0;
        foreach (expLine[i]) begin
          vectors++;
          if (lineLog[i] !== expLine[i] || busyLog[i] !== expBusy[i]) begin
            miscompares++;
            $display("[TB] FAIL parity_wave[%0d][%0d]: line/busy got %b/%b expected %b/%b",
                     t, i, lineLog[i], busyLog[i], expLine[i], expBusy[i]);
          end
          if (busyLog[i] === 1'b1) busyCycles++;
        end
        vectors++;
        if (busyCycles != frame_len(tbl[t].presc, tbl[t].parEn, tbl[t].stop2)) begin
          miscompares++; $display("[TB] FAIL parity_busy_len[%0d]: got %0d cycles expected %0d", t, busyCycles,
                                  frame_len(tbl[t].presc, tbl[t].parEn, tbl[t].stop2));
        end
      end
    end
  endtask

  task automatic test_random_frames;
    frame_cfg_t c;
    for (int t = 0; t < 6; t++) begin
      c.w      = DW'($urandom);
      c.presc  = int'($urandom_range(0, 5));
      c.parEn  = 1'($urandom);
      c.parTyp = 1'($urandom);
      c.stop2  = 1'($urandom);
      PRESCALE = PW'(c.presc);
      PAR_EN   = c.parEn;
      PAR_TYP  = c.parTyp;
      STOP2    = c.stop2;
      start_capture();
      add_frame(c);
      add_idle_tail(2);
      inIf.TX_IN_V = 1'b1;
      inIf.TX_IN_P = c.w;
      @(negedge CLK);
      inIf.TX_IN_V = 1'b0;
      repeat (expLine.size() - 1) @(negedge CLK);
      vectors++;
      if (lineLog.size() < expLine.size()) begin
        miscompares++; $display("[TB] FAIL random_len[%0d]: got %0d samples expected %0d", t, lineLog.size(), expLine.size());
      end else begin
        foreach (expLine[i]) begin
          vectors++;
          if (lineLog[i] !== expLine[i] || busyLog[i] !== expBusy[i]) begin
            miscompares++;
            $display("[TB] FAIL random_wave[%0d][%0d] w=%h p=%0d: line/busy got %b/%b expected %b/%b",
                     t, i, c.w, c.presc, lineLog[i], busyLog[i], expLine[i], expBusy[i]);
          end
        end
      end
    end
  endtask

  // Burst of writes with a reference FIFO model; writes continue past full to check dropping.
  task automatic test_burst_overflow;
    frame_cfg_t c;
    logic [DW-1:0] accepted[$];
    logic [DW-1:0] data;
    bit v, push, pop;
    int cnt, busyLeft, len;
    c = '{w: '0, presc: 4, parEn: 1'b0, parTyp: PAR_EVEN, stop2: 1'b0};
    len = frame_len(c.presc, c.parEn, c.stop2);
    PRESCALE = PW'(c.presc);
    PAR_EN   = c.parEn;
    PAR_TYP  = c.parTyp;
    STOP2    = c.stop2;
    cnt = 0;
    busyLeft = 0;
    start_capture();
    for (int k = 0; k < 12; k++) begin
      v    = (k < 9);
      data = DW'($urandom);
      inIf.TX_IN_V = v;
      inIf.TX_IN_P = data;
      push = v && (cnt != DEPTH);
      pop  = 1'b0;
      if (busyLeft <= 1) begin
        if (cnt > 0) begin pop = 1'b1; busyLeft = len; end
        else busyLeft = 0;
      end else busyLeft--;
      if (push) accepted.push_back(data);
      cnt = cnt + int'(push) - int'(pop);
      @(negedge CLK);
      vectors += 2;
      if (FIFO_CNT !== CW'(cnt)) begin
        miscompares++; $display("[TB] FAIL burst_cnt[%0d]: got %0d expected %0d", k, FIFO_CNT, cnt);
      end
      if (inIf.TX_IN_RDY !== (cnt != DEPTH)) begin
        miscompares++; $display("[TB] FAIL burst_rdy[%0d]: got %b expected %b", k, inIf.TX_IN_RDY, cnt != DEPTH);
      end
    end
    inIf.TX_IN_V = 1'b0;
    foreach (accepted[i]) begin
      c.w = accepted[i];
      add_frame(c);
    end
    add_idle_tail(3);
    repeat (expLine.size() - lineLog.size()) @(negedge CLK);
    vectors++;
    if (lineLog.size() < expLine.size()) begin
      miscompares++; $display("[TB] FAIL burst_len: got %0d samples expected %0d", lineLog.size(), expLine.size());
    end else begin
      foreach (expLine[i]) begin
        vectors++;
        if (lineLog[i] !== expLine[i] || busyLog[i] !== expBusy[i]) begin
          miscompares++;
          $display("[TB] FAIL burst_wave[%0d]: line/busy got %b/%b expected %b/%b",
                   i, lineLog[i], busyLog[i], expLine[i], expBusy[i]);
        end
      end
    end
  endtask

  task automatic test_config_change;
    frame_cfg_t c0, c1;
    c0 = '{w: DW'($urandom), presc: 4, parEn: 1'b1, parTyp: PAR_EVEN, stop2: 1'b0};
    c1 = '{w: DW'($urandom), presc: 2, parEn: 1'b0, parTyp: PAR_ODD,  stop2: 1'b0};
    PRESCALE = PW'(c0.presc);
    PAR_EN   = c0.parEn;
    PAR_TYP  = c0.parTyp;
    STOP2    = c0.stop2;
    start_capture();
    add_frame(c0);
    add_frame(c1);
    add_idle_tail(3);
    inIf.TX_IN_V = 1'b1;
    inIf.TX_IN_P = c0.w;
    @(negedge CLK);
    inIf.TX_IN_P = c1.w;
    @(negedge CLK);
    inIf.TX_IN_V = 1'b0;
    repeat (8) @(negedge CLK);
    PRESCALE = PW'(c1.presc);
    PAR_EN   = c1.parEn;
    PAR_TYP  = c1.parTyp;
    repeat (expLine.size() - lineLog.size()) @(negedge CLK);
    vectors++;
    if (lineLog.size() < expLine.size()) begin
      miscompares++; $display("[TB] FAIL cfg_len: got %0d samples expected %0d", lineLog.size(), expLine.size());
    end else begin
      foreach (expLine[i]) begin
        vectors++;
        if (lineLog[i] !== expLine[i] || busyLog[i] !== expBusy[i]) begin
          miscompares++;
          $display("[TB] FAIL cfg_wave[%0d]: line/busy got %b/%b expected %b/%b",
                   i, lineLog[i], busyLog[i], expLine[i], expBusy[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    PRESCALE = 8'd4;
    PAR_EN   = 1'b1;
    PAR_TYP  = PAR_EVEN;
    STOP2    = 1'b0;
    inIf.TX_IN_V = 1'b1;
    inIf.TX_IN_P = 8'h00;
    @(negedge CLK);
    inIf.TX_IN_P = 8'h5A;
    @(negedge CLK);
    inIf.TX_IN_V = 1'b0;
    repeat (10) @(negedge CLK);
    vectors += 2;
    if (BUSY !== 1'b1 || TX_OUT_S !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midframe_pre: busy/tx got %b/%b expected 1/0", BUSY, TX_OUT_S);
    end
    if (FIFO_CNT !== CW'(1)) begin
      miscompares++; $display("[TB] FAIL midframe_pre_cnt: got %0d expected 1", FIFO_CNT);
    end
    #2 RST = 1'b0;
    #1;
    vectors += 4;
    if (TX_OUT_S !== 1'b1) begin miscompares++; $display("[TB] FAIL midframe_tx: got %b expected 1", TX_OUT_S); end
    if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_busy: got %b expected 0", BUSY); end
    if (FIFO_CNT !== CW'(0)) begin miscompares++; $display("[TB] FAIL midframe_cnt: got %0d expected 0", FIFO_CNT); end
    if (inIf.TX_IN_RDY !== 1'b1) begin miscompares++; $display("[TB] FAIL midframe_rdy: got %b expected 1", inIf.TX_IN_RDY); end
    @(negedge CLK);
    RST = 1'b1;
    start_capture();
    repeat (60) @(negedge CLK);
    bad = 0;
    foreach (lineLog[i]) if (lineLog[i] !== 1'b1 || busyLog[i] !== 1'b0) bad++;
    vectors += 2;
    if (bad != 0 || lineLog.size() < 60) begin
      miscompares++; $display("[TB] FAIL midframe_residual: %0d non-idle samples of %0d, expected 0 of 60", bad, lineLog.size());
    end
    if (FIFO_CNT !== CW'(0)) begin
      miscompares++; $display("[TB] FAIL midframe_after_cnt: got %0d expected 0", FIFO_CNT);
    end
  endtask

  initial begin
    RST          = 1'b0;
    inIf.TX_IN_V = 1'b0;
    inIf.TX_IN_P = '0;
    PRESCALE     = 8'd4;
    PAR_EN       = 1'b0;
    PAR_TYP      = PAR_EVEN;
    STOP2        = 1'b0;
    $display("[TB] starting uart_tx_buffered bench");
    test_reset;
    test_parity;
    test_random_frames;
    test_burst_overflow;
    test_config_change;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised UART transmitter with an integrated transmit FIFO and an on-chip baud divider, running from a single system clock. It accepts parallel words on a valid/ready handshake, buffers up to `DEPTH` of them, and serialises each as start, data (LSB first), optional parity and one or two stop bits. It is the next-generation TX half of the UART subsystem: it removes the need for a separate TX baud clock and lets the system controller queue bursts without polling `BUSY`.

## Interface
- `DATA_WIDTH`, 8: bits per data word, 5..9.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `PRESCALE_WIDTH`, 8: width of the bit-period divisor.

- `CLK` in 1: system clock.
- `RST` in 1: asynchronous, active-low reset.
- `TX_IN_P` in `DATA_WIDTH`: word to transmit.
- `TX_IN_V` in 1: `TX_IN_P` valid.
- `TX_IN_RDY` out 1: FIFO can accept a word (not full).
- `PRESCALE` in `PRESCALE_WIDTH`: `CLK` cycles per bit; 0 is treated as 1.
- `PAR_EN` in 1: append parity bit.
- `PAR_TYP` in 1: 0 = even, 1 = odd.
- `STOP2` in 1: two stop bits when 1.
- `TX_OUT_S` out 1: serial line, idle high.
- `BUSY` out 1: a frame is on the line.
- `FIFO_CNT` out `$clog2(DEPTH)+1`: occupied entries.

## Operation
- Write: a word is accepted on a rising edge with `TX_IN_V && TX_IN_RDY`. `TX_IN_RDY = (FIFO_CNT != DEPTH)`.
- A write while full is dropped, and the FIFO is unchanged.
- A write on the same edge as a pop is accepted only if the FIFO was not full before that edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge the head is popped into the shift register, and `PAR_EN`, `PAR_TYP`, `STOP2` and the effective `PRESCALE` are latched for the whole frame.
  - START → DATA after one bit period.
  - DATA shifts LSB first. It goes to PARITY after `DATA_WIDTH` bits if `PAR_EN`, otherwise to STOP.
  - PARITY → STOP after one bit period.
  - STOP lasts one or two bit periods. It then goes to START (popping the next word) if the FIFO is non-empty, otherwise to IDLE. Back-to-back frames have no idle gap.
- Parity bit: XOR of the latched data, inverted when `PAR_TYP` = 1.
- Bit-period counter: counts 0..P-1, where P = max(`PRESCALE`, 1). The bit advances when the count reaches P-1.
- Line levels: `TX_OUT_S` is 0 in START, the data/parity bit in DATA/PARITY, and 1 in STOP and IDLE.
- `BUSY` is 1 in every state except IDLE.
- Changes to config inputs mid-frame have no effect until the next START.
- Reset values: `TX_OUT_S` = 1, `BUSY` = 0, `TX_IN_RDY` = 1, `FIFO_CNT` = 0; FSM in IDLE; FIFO pointers cleared.
- Reset mid-frame aborts the frame immediately, and `TX_OUT_S` returns high asynchronously.

## Timing
- `TX_OUT_S` and `BUSY` are registered outputs.
- Latency: a word written at edge N into an empty FIFO while IDLE drives `TX_OUT_S` = 0 and `BUSY` = 1 from edge N+1.
- Frame length is (2 + `DATA_WIDTH` + `PAR_EN` + `STOP2`) × P cycles.
- `FIFO_CNT` and `TX_IN_RDY` update on the edge after a write or pop. A simultaneous write and pop leaves the count unchanged.
- Pointers wrap modulo `DEPTH`. Full/empty are distinguished by the count, not by pointer equality.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE, START, DATA, PARITY, STOP) and parity-type constants (`PAR_EVEN` = 0, `PAR_ODD` = 1). The RX side reuses them.
- One sub-module, `uart_sync_fifo`, parametrised by `DATA_WIDTH` and `DEPTH`, with push/pop/full/empty/count ports.
- The FSM, baud counter, bit counter and shift register live in the top.

## Test plan
- Even parity: `DATA_WIDTH`=8, `PRESCALE`=4, `PAR_EN`=1, `PAR_TYP`=0, write 0xA5 → line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles. `BUSY` high exactly 44 cycles.
- Odd parity: same word with `PAR_TYP`=1 → parity bit 1. With `PAR_EN`=0, `STOP2`=1 → 11 bits ending in two stop bits, 44 cycles.
- Burst and full: write 5 words back-to-back with `DEPTH`=4 while IDLE → first word popped at edge+1. All 5 are accepted; `TX_IN_RDY` drops when `FIFO_CNT` reaches 4; 5 frames go out with no idle gap between them.
- Overflow: hold `TX_IN_V` while full → extra words are dropped, `FIFO_CNT` stays 4, and the later output matches only the accepted words.
- Config change and zero prescale: change `PRESCALE` 4→2 and toggle `PAR_EN` mid-frame → the current frame is unaffected and the next frame uses the new values. `PRESCALE`=0 → 1-cycle bits.
- Reset mid-frame: assert `RST` low during DATA → `TX_OUT_S`=1, `BUSY`=0, `FIFO_CNT`=0 immediately. After release, no residual frame is sent.
